// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the debug loader.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_LOCK     = 8
`ifdef DMEM_ARB_STATS_EN
  , parameter int unsigned CNT_W      = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cpu_MemRead,
  input  logic        i_cpu_MemWrite,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_WriteData,
  output logic [31:0] o_cpu_ReadData,
  output logic        o_cpu_stall,
  input  logic        i_ld_req,
  input  logic        i_ld_we,
  input  logic        i_ld_lock,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_wdata,
  output logic        o_ld_gnt,
  output logic        o_ld_rvalid,
  output logic [31:0] o_ld_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_WriteData,
  output logic        o_mem_MemRead,
  output logic        o_mem_MemWrite,
  input  logic [31:0] i_mem_ReadData
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] o_stall_cnt
  , output logic [CNT_W-1:0] o_forced_cnt
`endif
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {StCpuPri, StLdLock, StRelease} state_e;

  state_e        r_state, w_state_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_nxt;
  logic [LW-1:0] r_lock_cnt, w_lock_nxt, w_lock_sum;
  logic          w_cpu_req, w_cpu_gnt, w_ld_gnt, w_starved;
  logic          r_ld_rvalid;
  logic [31:0]   r_ld_rdata;

  assign w_cpu_req  = i_cpu_MemRead | i_cpu_MemWrite;
  assign w_starved  = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_lock_sum = r_lock_cnt + LW'(w_ld_gnt);

  always_comb begin
    w_ld_gnt  = 1'b0;
    w_cpu_gnt = 1'b0;
    unique case (r_state)
      StCpuPri: begin
        w_ld_gnt  = i_ld_req & (~w_cpu_req | w_starved);
        w_cpu_gnt = w_cpu_req & ~w_ld_gnt;
      end
      StLdLock:  w_ld_gnt  = i_ld_req;
      StRelease: w_cpu_gnt = w_cpu_req;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    unique case (r_state)
      StCpuPri: begin
        if (w_ld_gnt && i_ld_lock) begin
          w_state_nxt = StLdLock;
          w_lock_nxt  = LW'(1);
        end
      end
      StLdLock: begin
        // Burst limit wins over a voluntary exit in the same cycle.
        if (w_lock_sum >= LW'(MAX_LOCK)) begin
          w_state_nxt = StRelease;
          w_lock_nxt  = '0;
        end else if (!i_ld_lock || !i_ld_req) begin
          w_state_nxt = StCpuPri;
          w_lock_nxt  = '0;
        end else begin
          w_lock_nxt  = w_lock_sum;
        end
      end
      StRelease: begin
        w_state_nxt = StCpuPri;
        w_lock_nxt  = '0;
      end
      default: begin
        w_state_nxt = StCpuPri;
        w_lock_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!i_ld_req || w_ld_gnt) begin
      w_starve_nxt = '0;
    end else if (!w_starved) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StCpuPri;
      r_starve_cnt <= '0;
      r_lock_cnt   <= '0;
      r_ld_rvalid  <= 1'b0;
      r_ld_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_lock_cnt   <= w_lock_nxt;
      r_ld_rvalid  <= w_ld_gnt & ~i_ld_we;
      if (w_ld_gnt && !i_ld_we) begin
        r_ld_rdata <= i_mem_ReadData;
      end
    end
  end

  always_comb begin
    o_mem_addr      = '0;
    o_mem_WriteData = '0;
    o_mem_MemRead   = 1'b0;
    o_mem_MemWrite  = 1'b0;
    if (w_ld_gnt) begin
      o_mem_addr      = i_ld_addr;
      o_mem_WriteData = i_ld_wdata;
      o_mem_MemRead   = ~i_ld_we;
      o_mem_MemWrite  = i_ld_we;
    end else if (w_cpu_gnt) begin
      o_mem_addr      = i_cpu_addr;
      o_mem_WriteData = i_cpu_WriteData;
      o_mem_MemRead   = i_cpu_MemRead;
      o_mem_MemWrite  = i_cpu_MemWrite;
    end
  end

  assign o_cpu_ReadData = w_cpu_gnt ? i_mem_ReadData : 32'h0;
  assign o_cpu_stall    = w_cpu_req & ~w_cpu_gnt;
  assign o_ld_gnt       = w_ld_gnt;
  assign o_ld_rvalid    = r_ld_rvalid;
  assign o_ld_rdata     = r_ld_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_forced_cnt;
  logic             w_forced;

  assign w_forced = (r_state == StCpuPri) & w_ld_gnt & w_cpu_req & w_starved;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_forced_cnt <= '0;
    end else begin
      if (o_cpu_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_forced && (r_forced_cnt != '1)) begin
        r_forced_cnt <= r_forced_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_forced_cnt = r_forced_cnt;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small behavioural memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_cpu_MemRead, i_cpu_MemWrite;
  logic [31:0] i_cpu_addr, i_cpu_WriteData, o_cpu_ReadData;
  logic        o_cpu_stall;
  logic        i_ld_req, i_ld_we, i_ld_lock;
  logic [31:0] i_ld_addr, i_ld_wdata;
  logic        o_ld_gnt, o_ld_rvalid;
  logic [31:0] o_ld_rdata;
  logic [31:0] o_mem_addr, o_mem_WriteData, i_mem_ReadData;
  logic        o_mem_MemRead, o_mem_MemWrite;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] o_stall_cnt, o_forced_cnt;
`endif

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int n_vec = 0;
  int n_err = 0;
  int idx;

  always #5 clk = ~clk;

  assign i_mem_ReadData = mem[o_mem_addr[9:2]];

  always @(posedge clk) begin
    if (o_mem_MemWrite) mem[o_mem_addr[9:2]] <= o_mem_WriteData;
    else if (pre_we)    mem[pre_idx] <= pre_data;
  end

  dmem_port_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .i_cpu_MemRead   (i_cpu_MemRead),
    .i_cpu_MemWrite  (i_cpu_MemWrite),
    .i_cpu_addr      (i_cpu_addr),
    .i_cpu_WriteData (i_cpu_WriteData),
    .o_cpu_ReadData  (o_cpu_ReadData),
    .o_cpu_stall     (o_cpu_stall),
    .i_ld_req        (i_ld_req),
    .i_ld_we         (i_ld_we),
    .i_ld_lock       (i_ld_lock),
    .i_ld_addr       (i_ld_addr),
    .i_ld_wdata      (i_ld_wdata),
    .o_ld_gnt        (o_ld_gnt),
    .o_ld_rvalid     (o_ld_rvalid),
    .o_ld_rdata      (o_ld_rdata),
    .o_mem_addr      (o_mem_addr),
    .o_mem_WriteData (o_mem_WriteData),
    .o_mem_MemRead   (o_mem_MemRead),
    .o_mem_MemWrite  (o_mem_MemWrite),
    .i_mem_ReadData  (i_mem_ReadData)
`ifdef DMEM_ARB_STATS_EN
    , .o_stall_cnt   (o_stall_cnt)
    , .o_forced_cnt  (o_forced_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] i, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = i; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  initial begin
    i_cpu_MemRead = 0; i_cpu_MemWrite = 0; i_cpu_addr = '0; i_cpu_WriteData = '0;
    i_ld_req = 0; i_ld_we = 0; i_ld_lock = 0; i_ld_addr = '0; i_ld_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", 32'(o_ld_rvalid), 32'd0);
    chk("rst_rdata", o_ld_rdata, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_rdwr", {30'd0, o_mem_MemRead, o_mem_MemWrite}, 32'd0);
    chk("rst_gnt_stall", {30'd0, o_ld_gnt, o_cpu_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    preload(8'h04, 32'hDEADBEEF);
    preload(8'h20, 32'h0000_1234);

    // CPU read with loader idle
    @(negedge clk);
    i_cpu_MemRead = 1; i_cpu_addr = 32'h10;
    #1;
    chk("cpu_rd_data", o_cpu_ReadData, 32'hDEADBEEF);
    chk("cpu_rd_stall", 32'(o_cpu_stall), 32'd0);
    chk("cpu_rd_gnt", 32'(o_ld_gnt), 32'd0);
    chk("cpu_rd_memrd", 32'(o_mem_MemRead), 32'd1);

    // Starvation: loader write denied 4 cycles, forced on the 5th
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      i_ld_req = 1; i_ld_we = 1; i_ld_lock = 0; i_ld_addr = 32'h40; i_ld_wdata = 32'h55;
      #1;
      chk($sformatf("starve_gnt_%0d", k), 32'(o_ld_gnt), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("starve_stall_%0d", k), 32'(o_cpu_stall), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("starve_memwr", {o_mem_addr[30:0], o_mem_MemWrite}, {31'h40, 1'b1});
    @(negedge clk);
    i_ld_req = 0; i_cpu_addr = 32'h40;
    #1;
    chk("starve_after_stall", 32'(o_cpu_stall), 32'd0);
    chk("starve_wr_no_rvalid", 32'(o_ld_rvalid), 32'd0);
    chk("starve_wr_data", o_cpu_ReadData, 32'h55);

    // Loader read with CPU idle
    @(negedge clk);
    i_cpu_MemRead = 0;
    i_ld_req = 1; i_ld_we = 0; i_ld_addr = 32'h80;
    #1;
    chk("ldrd_gnt", 32'(o_ld_gnt), 32'd1);
    chk("ldrd_mem", {o_mem_addr[30:0], o_mem_MemRead}, {31'h80, 1'b1});
    @(negedge clk);
    i_ld_req = 0;
    #1;
    chk("ldrd_rvalid", 32'(o_ld_rvalid), 32'd1);
    chk("ldrd_rdata", o_ld_rdata, 32'h1234);
    @(negedge clk);
    #1;
    chk("ldrd_rvalid_drop", 32'(o_ld_rvalid), 32'd0);

    // Simultaneous CPU write and loader read: CPU wins, starve_cnt becomes 1
    @(negedge clk);
    i_cpu_MemWrite = 1; i_cpu_addr = 32'h44; i_cpu_WriteData = 32'hA5A5A5A5;
    i_ld_req = 1; i_ld_we = 0; i_ld_addr = 32'h80;
    #1;
    chk("simul_memwr", {o_mem_addr[30:0], o_mem_MemWrite}, {31'h44, 1'b1});
    chk("simul_gnt", 32'(o_ld_gnt), 32'd0);
    chk("simul_stall", 32'(o_cpu_stall), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      i_cpu_MemWrite = 0; i_cpu_MemRead = 1; i_cpu_addr = 32'h10;
      #1;
      chk($sformatf("simul_gnt_%0d", k), 32'(o_ld_gnt), (k == 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    i_ld_req = 0; i_cpu_addr = 32'h44;
    #1;
    chk("simul_rvalid", 32'(o_ld_rvalid), 32'd1);
    chk("simul_rdata", o_ld_rdata, 32'h1234);
    chk("simul_cpu_wr", o_cpu_ReadData, 32'hA5A5A5A5);

    // Locked burst of 12 writes against a continuously requesting CPU
    @(negedge clk);
    i_cpu_addr = 32'h10;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (idx < 12) begin
        i_ld_req = 1; i_ld_we = 1; i_ld_lock = (idx < 11);
        i_ld_addr = 32'h100 + 32'(idx) * 4; i_ld_wdata = 32'h1000 + 32'(idx);
      end else begin
        i_ld_req = 0;
      end
      #1;
      chk($sformatf("burst_gnt_%0d", c), 32'(o_ld_gnt),
          ((c >= 4 && c <= 11) || (c >= 16)) ? 32'd1 : 32'd0);
      chk($sformatf("burst_stall_%0d", c), 32'(o_cpu_stall),
          ((c >= 4 && c <= 11) || (c >= 16)) ? 32'd1 : 32'd0);
      if (c == 12) chk("burst_release_cpu", {o_mem_addr[30:0], o_mem_MemRead}, {31'h10, 1'b1});
      if (o_ld_gnt) idx++;
    end
    chk("burst_count", 32'(idx), 32'd12);
    @(negedge clk);
    i_ld_req = 0; i_ld_lock = 0; i_cpu_addr = 32'h11C;
    #1;
    chk("burst_exit_stall", 32'(o_cpu_stall), 32'd0);
    chk("burst_word7", o_cpu_ReadData, 32'h1007);
    @(negedge clk);
    i_cpu_addr = 32'h12C;
    #1;
    chk("burst_word11", o_cpu_ReadData, 32'h100B);

    // Reset in the middle of a lock after 3 grants
    @(negedge clk);
    i_cpu_MemRead = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_ld_req = 1; i_ld_we = 0; i_ld_lock = 1; i_ld_addr = 32'h80;
      #1;
      chk($sformatf("lockrst_gnt_%0d", c), 32'(o_ld_gnt), 32'd1);
    end
    chk("lockrst_rvalid_pre", 32'(o_ld_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("lockrst_rvalid_clr", 32'(o_ld_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    i_ld_req = 0; i_ld_lock = 0;
    i_cpu_MemRead = 1; i_cpu_addr = 32'h10;
    #1;
    chk("lockrst_stall", 32'(o_cpu_stall), 32'd0);
    chk("lockrst_cpu_data", o_cpu_ReadData, 32'hDEADBEEF);
    chk("lockrst_rvalid", 32'(o_ld_rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (addr / write-data / MemRead / MemWrite, combinational read, write on clk edge) between two requesters.
- Requester 0: the pipeline MEM stage (CPU). Requester 1: the program/data loader (debug UART loader).
- CPU has priority by default. Loader is protected by a starvation counter and may lock the port for short bursts.
- CPU losing arbitration is held via a stall output to the hazard unit.

Parameters:
- STARVE_LIMIT, 4, max consecutive cycles a requesting loader may be denied before a forced grant.
- MAX_LOCK, 8, max consecutive granted loader cycles under lock before a forced one-cycle release.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_cpu_MemRead  in  1  CPU read request
- i_cpu_MemWrite  in  1  CPU write request
- i_cpu_addr  in  32  CPU byte address
- i_cpu_WriteData  in  32  CPU write data
- o_cpu_ReadData  out  32  CPU read data, combinational passthrough when granted, else 0
- o_cpu_stall  out  1  CPU requesting and not granted this cycle
- i_ld_req  in  1  loader request (level)
- i_ld_we  in  1  loader write (1) / read (0)
- i_ld_lock  in  1  loader asks to keep ownership after this access
- i_ld_addr  in  32  loader byte address
- i_ld_wdata  in  32  loader write data
- o_ld_gnt  out  1  loader access performed this cycle (combinational)
- o_ld_rvalid  out  1  registered, one cycle after a granted loader read
- o_ld_rdata  out  32  registered read data, valid with o_ld_rvalid
- o_mem_addr  out  32  to memory
- o_mem_WriteData  out  32  to memory
- o_mem_MemRead  out  1  to memory
- o_mem_MemWrite  out  1  to memory
- i_mem_ReadData  in  32  from memory

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: o_ld_rvalid=0, o_ld_rdata=0, starve_cnt=0, lock_cnt=0, state=CPU_PRI. All combinational outputs follow from the reset state, so with no requests every memory-side output is 0.
- Definitions: cpu_req = i_cpu_MemRead | i_cpu_MemWrite. Both CPU bits are passed through unchanged.
- States:
  - CPU_PRI: loader granted iff i_ld_req & (~cpu_req | starve_cnt==STARVE_LIMIT). Otherwise the CPU is granted if requesting.
  - LD_LOCK: loader granted whenever i_ld_req. CPU stalled if requesting.
  - RELEASE: exactly one cycle. Loader never granted; CPU granted if requesting.
- Transitions:
  - CPU_PRI -> LD_LOCK: on a loader grant with i_ld_lock=1.
  - LD_LOCK -> CPU_PRI: when i_ld_lock=0 or i_ld_req=0 at a clock edge.
  - LD_LOCK -> RELEASE: when lock_cnt reaches MAX_LOCK. This has precedence over the exit to CPU_PRI.
  - RELEASE -> CPU_PRI: unconditional.
- lock_cnt: counts loader grants since entering LD_LOCK, including the entry grant. Cleared on leaving LD_LOCK.
- starve_cnt: increments each cycle with i_ld_req=1 and o_ld_gnt=0, saturating at STARVE_LIMIT. Cleared to 0 on any loader grant or when i_ld_req=0.
- Memory mux:
  - Granted requester drives o_mem_* (loader: MemRead=~i_ld_we, MemWrite=i_ld_we).
  - With no grant, o_mem_MemRead = o_mem_MemWrite = 0, and addr/WriteData are 0.
  - A stalled CPU never causes a memory write.
- Latency:
  - CPU: zero-cycle read when granted.
  - Loader: gnt in cycle N, o_ld_rvalid/o_ld_rdata at N+1 (reads only). Writes produce no rvalid.
- Handshake: the loader holds req/addr/data stable until it sees o_ld_gnt, and may present a new request in the cycle after gnt.
- o_cpu_stall = cpu_req & ~cpu_granted, purely combinational, with no registered delay.
- Reset mid-lock or mid-starvation returns to CPU_PRI immediately and drops any pending rvalid.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, add outputs o_stall_cnt[CNT_W] and o_forced_cnt[CNT_W]. Both are saturating counters, cleared by reset.
  - o_stall_cnt: cycles with o_cpu_stall=1.
  - o_forced_cnt: loader grants caused by starve_cnt==STARVE_LIMIT.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- CPU read addr 0x10 with loader idle, memory word = 0xDEADBEEF -> o_cpu_ReadData=0xDEADBEEF same cycle, o_cpu_stall=0, o_ld_gnt=0.
- CPU read held every cycle plus loader write addr 0x40 data 0x55 -> loader denied 4 cycles, granted cycle 5, o_cpu_stall=1 that cycle only, memory word 0x10 = 0x55.
- Loader read while CPU idle, memory word 0x20 = 0x1234 -> o_ld_gnt same cycle, o_ld_rvalid=1 and o_ld_rdata=0x1234 next cycle.
- Loader lock burst of 12 writes with CPU requesting continuously -> 8 consecutive loader grants, 1 RELEASE cycle with CPU granted, then CPU_PRI (loader waits per starvation rule).
- CPU write and loader request simultaneously in CPU_PRI, starve_cnt=0 -> CPU write performed, loader not granted, starve_cnt=1.
- Reset asserted during LD_LOCK after 3 grants -> next cycle CPU request granted with no stall, o_ld_rvalid=0.
